// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//   Instruction-fetch front end. Issues word-aligned requests to instruction
//   memory (req/gnt/rvalid, in-order responses) with up to MAX_OUTSTANDING
//   requests in flight. Returned words land in a FIFO_DEPTH-entry prefetch
//   queue that feeds the ID stage with valid/ready. A prioritised redirect
//   mux selects branch, trap, mret, dret or debug targets. A redirect flushes
//   the queue and marks every in-flight response as stale.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   fetch_enable_i          start fetching from boot_addr_i
//   boot_addr_i             reset fetch address (also debug entry base)
//   redirect_i / _sel_i     one-cycle redirect strobe and its source
//   pc_dest_i, irq_cause_i  branch target, interrupt cause
//   csr_mtvec_i/mepc/depc   trap vector, mret and dret targets
//   imem_*                  instruction memory request/response channel
//   if_valid_o/instr/pc/err queue head towards ID, accepted by id_ready_i
//   busy_o                  requests in flight or queue not empty
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter bit VEC_MODE_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_enable_i,
    input  logic [DATA_WIDTH-1:0] boot_addr_i,
    input  logic                  redirect_i,
    input  logic [2:0]            redirect_sel_i,
    input  logic [DATA_WIDTH-1:0] pc_dest_i,
    input  logic [4:0]            irq_cause_i,
    input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0] csr_mepc_i,
    input  logic [DATA_WIDTH-1:0] csr_depc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_err_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic                  if_err_o,
    input  logic                  id_ready_i,
    output logic                  busy_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]           DEPTH_C     = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW:0]           MAXO_C      = (CW+1)'(MAX_OUTSTANDING);
    localparam logic [AW-1:0]         PTR_ONE_C   = AW'(1'b1);
    localparam logic [DATA_WIDTH-1:0] ADDR_STEP_C = DATA_WIDTH'(3'd4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0] fetch_addr_r, fetch_addr_nxt_s;
    logic [DATA_WIDTH-1:0] hold_addr_r;
    logic                  stale_r, stale_nxt_s;
    logic [CW-1:0]         out_cnt_r, out_cnt_nxt_s;
    logic [CW-1:0]         disc_cnt_r, disc_cnt_nxt_s;

    logic [DATA_WIDTH-1:0] q_pc_r    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_instr_r [FIFO_DEPTH];
    logic                  q_err_r   [FIFO_DEPTH];
    logic [AW-1:0]         q_wr_ptr_r, q_rd_ptr_r;
    logic [CW-1:0]         q_cnt_r;

    logic [DATA_WIDTH-1:0] trk_pc_r  [FIFO_DEPTH];
    logic [AW-1:0]         trk_wr_ptr_r, trk_rd_ptr_r;

    logic [DATA_WIDTH-1:0] bus_addr_s;
    logic [DATA_WIDTH-1:0] mtvec_base_s;
    logic [DATA_WIDTH-1:0] irq_off_s;
    logic [DATA_WIDTH-1:0] redirect_tgt_s;
    logic                  space_ok_s, slot_ok_s;
    logic                  gnt_fire_s, gnt_new_s, pend_s;
    logic                  rv_keep_s, rv_drop_s;
    logic                  push_s, pop_s, q_full_s;
    logic                  unused_s;

    assign unused_s     = csr_mtvec_i[1];
    assign mtvec_base_s = {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};
    assign irq_off_s    = {{(DATA_WIDTH-7){1'b0}}, irq_cause_i, 2'b00};

    // Queue room counts only live requests; the in-flight limit also counts
    // stale ones, because the PC tracker has to hold them until they return.
    assign space_ok_s = (({1'b0, q_cnt_r} + {1'b0, out_cnt_r}) < DEPTH_C);
    assign slot_ok_s  = (({1'b0, out_cnt_r} + {1'b0, disc_cnt_r}) < MAXO_C);

    assign gnt_fire_s = imem_req_o && imem_gnt_i;
    // A held request that was overtaken by a redirect is already in disc_cnt_r.
    assign gnt_new_s  = gnt_fire_s && !stale_r;
    // A request left pending by a redirect will be granted later and dropped.
    assign pend_s     = redirect_i && imem_req_o && !imem_gnt_i && !stale_r;
    assign rv_keep_s  = imem_rvalid_i && (disc_cnt_r == {CW{1'b0}});
    assign rv_drop_s  = imem_rvalid_i && (disc_cnt_r != {CW{1'b0}});
    assign push_s     = rv_keep_s && !redirect_i;
    assign pop_s      = if_valid_o && id_ready_i && !redirect_i;
    assign q_full_s   = (q_cnt_r == CW'(FIFO_DEPTH));

    // Redirect target mux; reserved source codes fall back to the trap base.
    always_comb begin
        redirect_tgt_s = mtvec_base_s;
        case (redirect_sel_i)
            3'd0: redirect_tgt_s = pc_dest_i;
            3'd1: redirect_tgt_s = mtvec_base_s;
            3'd2: begin
                if (VEC_MODE_EN && csr_mtvec_i[0]) begin
                    redirect_tgt_s = mtvec_base_s + irq_off_s;
                end else begin
                    redirect_tgt_s = mtvec_base_s;
                end
            end
            3'd3: redirect_tgt_s = csr_mepc_i;
            3'd4: redirect_tgt_s = csr_depc_i;
            3'd5: redirect_tgt_s = {boot_addr_i[DATA_WIDTH-1:8], 8'h80};
            default: redirect_tgt_s = mtvec_base_s;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; fetch_enable_i is only honoured when no request is up.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_enable_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (imem_req_o && !imem_gnt_i) begin
                    state_nxt_s = ST_HOLD;
                end else if (!imem_req_o && !fetch_enable_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (imem_gnt_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: request strobe and the address presented on the bus.
    always_comb begin
        imem_req_o = 1'b0;
        bus_addr_s = fetch_addr_r;
        case (state_r)
            ST_RUN: begin
                imem_req_o = space_ok_s && slot_ok_s;
                bus_addr_s = fetch_addr_r;
            end
            ST_HOLD: begin
                imem_req_o = 1'b1;
                bus_addr_s = hold_addr_r;
            end
            default: begin
                imem_req_o = 1'b0;
                bus_addr_s = fetch_addr_r;
            end
        endcase
        if (imem_req_o) begin
            imem_addr_o = {bus_addr_s[DATA_WIDTH-1:2], 2'b00};
        end else begin
            imem_addr_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Next fetch address, stale-hold flag and in-flight bookkeeping.
    always_comb begin
        fetch_addr_nxt_s = fetch_addr_r;
        stale_nxt_s      = stale_r;
        out_cnt_nxt_s    = out_cnt_r;
        disc_cnt_nxt_s   = disc_cnt_r;

        if (redirect_i) begin
            fetch_addr_nxt_s = redirect_tgt_s;
        end else if ((state_r == ST_IDLE) && fetch_enable_i) begin
            fetch_addr_nxt_s = boot_addr_i;
        end else if (gnt_new_s) begin
            fetch_addr_nxt_s = fetch_addr_r + ADDR_STEP_C;
        end else begin
            fetch_addr_nxt_s = fetch_addr_r;
        end

        if (redirect_i && imem_req_o && !imem_gnt_i) begin
            stale_nxt_s = 1'b1;
        end else if (gnt_fire_s) begin
            stale_nxt_s = 1'b0;
        end else begin
            stale_nxt_s = stale_r;
        end

        // On redirect every live request becomes one to drop.
        if (redirect_i) begin
            out_cnt_nxt_s  = {CW{1'b0}};
            disc_cnt_nxt_s = out_cnt_r + CW'(gnt_new_s) + disc_cnt_r + CW'(pend_s)
                           - CW'(rv_keep_s) - CW'(rv_drop_s);
        end else begin
            out_cnt_nxt_s  = out_cnt_r + CW'(gnt_new_s) - CW'(rv_keep_s);
            disc_cnt_nxt_s = disc_cnt_r - CW'(rv_drop_s);
        end
    end

    // Fetch address, held bus address and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_r <= {DATA_WIDTH{1'b0}};
            hold_addr_r  <= {DATA_WIDTH{1'b0}};
            stale_r      <= 1'b0;
            out_cnt_r    <= {CW{1'b0}};
            disc_cnt_r   <= {CW{1'b0}};
        end else begin
            fetch_addr_r <= fetch_addr_nxt_s;
            stale_r      <= stale_nxt_s;
            out_cnt_r    <= out_cnt_nxt_s;
            disc_cnt_r   <= disc_cnt_nxt_s;
            if ((state_r == ST_RUN) && imem_req_o && !imem_gnt_i) begin
                hold_addr_r <= fetch_addr_r;
            end else begin
                hold_addr_r <= hold_addr_r;
            end
        end
    end

    // PC tracker: one entry per granted request, retired by its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_wr_ptr_r <= {AW{1'b0}};
            trk_rd_ptr_r <= {AW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                trk_pc_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (gnt_fire_s) begin
                trk_pc_r[trk_wr_ptr_r] <= imem_addr_o;
                trk_wr_ptr_r           <= trk_wr_ptr_r + PTR_ONE_C;
            end
            if (imem_rvalid_i) begin
                trk_rd_ptr_r <= trk_rd_ptr_r + PTR_ONE_C;
            end
        end
    end

    // Prefetch queue; a redirect empties it and overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_wr_ptr_r <= {AW{1'b0}};
            q_rd_ptr_r <= {AW{1'b0}};
            q_cnt_r    <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_pc_r[i]    <= {DATA_WIDTH{1'b0}};
                q_instr_r[i] <= {DATA_WIDTH{1'b0}};
                q_err_r[i]   <= 1'b0;
            end
        end else if (redirect_i) begin
            q_wr_ptr_r <= {AW{1'b0}};
            q_rd_ptr_r <= {AW{1'b0}};
            q_cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                q_pc_r[q_wr_ptr_r]    <= trk_pc_r[trk_rd_ptr_r];
                q_instr_r[q_wr_ptr_r] <= imem_rdata_i;
                q_err_r[q_wr_ptr_r]   <= imem_err_i;
                q_wr_ptr_r            <= q_wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                q_rd_ptr_r <= q_rd_ptr_r + PTR_ONE_C;
            end
            q_cnt_r <= q_cnt_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign if_valid_o = (q_cnt_r != {CW{1'b0}});
    assign if_instr_o = if_valid_o ? q_instr_r[q_rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign if_pc_o    = if_valid_o ? q_pc_r[q_rd_ptr_r]    : {DATA_WIDTH{1'b0}};
    assign if_err_o   = if_valid_o ? q_err_r[q_rd_ptr_r]   : 1'b0;
    assign busy_o     = (out_cnt_r != {CW{1'b0}}) || if_valid_o
                     || (disc_cnt_r != {CW{1'b0}});

    if_prefetch_stage_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_s),
        .pop    (pop_s),
        .full   (q_full_s)
    );

endmodule

// ---------------------------------------------------------------------------
// if_prefetch_stage_chk
//   Run-time checks for the prefetch queue.
//   clk, rst_n  clock and reset of the checked block
//   push, pop   queue write/read strobes
//   full        queue holds FIFO_DEPTH entries
// ---------------------------------------------------------------------------
module if_prefetch_stage_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full
);

    // A push into a full queue without a matching pop would lose a word.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop));
        end
    end

endmodule
